// File: rtl/alu_op_pkg.sv
// rtl/alu_op_pkg.sv - shared ALU operation types and widths
package alu_op_pkg;

    localparam int DATA_W    = 2;
    localparam int SEL_W     = 2;
    localparam int ALU_RES_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SEL_W-1:0]  sel;
    } alu_op_t;

endpackage

// File: rtl/alu_op_queue.sv
// rtl/alu_op_queue.sv - FIFO of ALU operations with fall-through head; ALU_OP_QUEUE_STATS_EN adds issue/stall counters
module alu_op_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 2,
    parameter int SEL_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_a_i,
    input  logic [DATA_W-1:0]          in_b_i,
    input  logic [SEL_W-1:0]           in_sel_i,
    output logic                       op_valid_o,
    input  logic                       op_ready_i,
    output logic [DATA_W-1:0]          a_o,
    output logic [DATA_W-1:0]          b_o,
    output logic [SEL_W-1:0]           sel_o,
`ifdef ALU_OP_QUEUE_STATS_EN
    output logic [7:0]                 issued_cnt_o,
    output logic [7:0]                 stall_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    import alu_op_pkg::ALU_RES_W;

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH+1);
    localparam int ENTRY_W = 2*DATA_W + SEL_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]      wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push, pop;
    logic [ENTRY_W-1:0] head;

    assign in_ready_o = (count_q != CW'(DEPTH));
    assign op_valid_o = (count_q != '0);
    assign push       = in_valid_i & in_ready_o;
    assign pop        = op_valid_o & op_ready_i;
    assign head       = op_valid_o ? mem_q[rp_q] : '0;
    assign a_o        = head[ENTRY_W-1 -: DATA_W];
    assign b_o        = head[SEL_W +: DATA_W];
    assign sel_o      = head[SEL_W-1:0];
    assign count_o    = count_q;

    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush_i) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wp_q] = {in_a_i, in_b_i, in_sel_i};
                wp_d        = wp_q + 1'b1;
            end
            if (pop) begin
                rp_d = rp_q + 1'b1;
            end
            // push-only grows, pop-only shrinks, both leaves occupancy unchanged
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

`ifdef ALU_OP_QUEUE_STATS_EN
    logic [7:0] issued_q, issued_d, stall_q, stall_d;

    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (flush_i) begin
            issued_d = '0;
            stall_d  = '0;
        end else begin
            if (pop) begin
                issued_d = issued_q + 8'd1;
            end
            // stall count saturates so long back-pressure stays visible
            if (in_valid_i && !in_ready_o && stall_q != 8'hff) begin
                stall_d = stall_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign issued_cnt_o = issued_q;
    assign stall_cnt_o  = stall_q;
`endif

endmodule

// File: tb/tb_alu_op_queue.sv
// tb/tb_alu_op_queue.sv - scoreboard bench for alu_op_queue
module tb_alu_op_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n, flush_i, in_valid_i, in_ready_o, op_valid_o, op_ready_i;
    logic [1:0] in_a_i, in_b_i, in_sel_i, a_o, b_o, sel_o;
    logic [2:0] count_o;
`ifdef ALU_OP_QUEUE_STATS_EN
    logic [7:0] issued_cnt_o, stall_cnt_o;
`endif

    int nvec  = 0;
    int nfail = 0;
    logic [5:0] exp_q[$];
    logic [5:0] tmp;

    always #5 clk = ~clk;

    alu_op_queue #(.DEPTH(DEPTH), .DATA_W(2), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i), .in_sel_i(in_sel_i),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
        .a_o(a_o), .b_o(b_o), .sel_o(sel_o),
`ifdef ALU_OP_QUEUE_STATS_EN
        .issued_cnt_o(issued_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
        .count_o(count_o)
    );

    // Advances the reference queue by the handshakes visible this cycle, then clocks.
    task automatic tick();
        bit mpush, mpop;
        mpush = in_valid_i && (exp_q.size() != DEPTH);
        mpop  = op_ready_i && (exp_q.size() != 0);
        if (flush_i) begin
            exp_q.delete();
        end else begin
            if (mpop) tmp = exp_q.pop_front();
            if (mpush) exp_q.push_back({in_a_i, in_b_i, in_sel_i});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
        in_valid_i = v;
        in_a_i     = a;
        in_b_i     = b;
        in_sel_i   = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; op_ready_i = 1'b0;
        drive(1'b1, 2'd1, 2'd2, 2'd3);
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({in_ready_o, op_valid_o, count_o} !== {1'b1, 1'b0, 3'd0}) begin
            nfail++;
            $display("FAIL reset_flags got=%b exp=%b", {in_ready_o, op_valid_o, count_o}, 5'b10000);
        end
        nvec++;
        if ({a_o, b_o, sel_o} !== 6'd0) begin
            nfail++;
            $display("FAIL reset_data got=%h exp=0", {a_o, b_o, sel_o});
        end
        rst_n = 1'b1;
        #1;
        nvec++;
        if (op_valid_o !== 1'b0) begin
            nfail++;
            $display("FAIL reset_no_same_cycle got=%b exp=0", op_valid_o);
        end
        tick();
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        nvec++;
        if (op_valid_o !== 1'b1 || count_o !== 3'd1 || {a_o, b_o, sel_o} !== exp_q[0]) begin
            nfail++;
            $display("FAIL reset_first_push got=%b/%0d/%h exp=1/1/%h", op_valid_o, count_o, {a_o, b_o, sel_o}, exp_q[0]);
        end
    endtask

    task automatic test_order();
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        op_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 2'(i), 2'd0);
            tick();
        end
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        nvec++;
        if (count_o !== 3'd4 || in_ready_o !== 1'b0) begin
            nfail++;
            $display("FAIL order_full got=%0d/%b exp=4/0", count_o, in_ready_o);
        end
        op_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (op_valid_o !== 1'b1 || a_o !== 2'(i) || b_o !== 2'(i) || {a_o, b_o, sel_o} !== exp_q[0]) begin
                nfail++;
                $display("FAIL order_pop%0d got=%b/%h exp=1/%h", i, op_valid_o, {a_o, b_o, sel_o}, {2'(i), 2'(i), 2'd0});
            end
            tick();
        end
        nvec++;
        if (op_valid_o !== 1'b0 || {a_o, b_o, sel_o} !== 6'd0) begin
            nfail++;
            $display("FAIL order_empty got=%b/%h exp=0/0", op_valid_o, {a_o, b_o, sel_o});
        end
        op_ready_i = 1'b0;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(3 - i), 2'(i), 2'(i));
            tick();
        end
        drive(1'b1, 2'd2, 2'd1, 2'd3);
        op_ready_i = 1'b1;
        tick();
        nvec++;
        if (count_o !== 3'd3 || in_ready_o !== 1'b1) begin
            nfail++;
            $display("FAIL full_pop_nopush got=%0d/%b exp=3/1", count_o, in_ready_o);
        end
        tick();
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        nvec++;
        if (count_o !== 3'd3) begin
            nfail++;
            $display("FAIL full_pop_land got=%0d exp=3", count_o);
        end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if ({a_o, b_o, sel_o} !== exp_q[0]) begin
                nfail++;
                $display("FAIL full_pop_drain%0d got=%h exp=%h", i, {a_o, b_o, sel_o}, exp_q[0]);
            end
            tick();
        end
        nvec++;
        if (op_valid_o !== 1'b0 || exp_q.size() != 0) begin
            nfail++;
            $display("FAIL full_pop_empty got=%b exp=0", op_valid_o);
        end
        op_ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        op_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'(i + 1), 2'(i), 2'(i + 2));
            tick();
        end
        op_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)));
            nvec++;
            if (count_o !== 3'd2 || {a_o, b_o, sel_o} !== exp_q[0]) begin
                nfail++;
                $display("FAIL wrap%0d got=%0d/%h exp=2/%h", i, count_o, {a_o, b_o, sel_o}, exp_q[0]);
            end
            tick();
        end
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if ({a_o, b_o, sel_o} !== exp_q[0]) begin
                nfail++;
                $display("FAIL wrap_drain%0d got=%h exp=%h", i, {a_o, b_o, sel_o}, exp_q[0]);
            end
            tick();
        end
        op_ready_i = 1'b0;
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'(i), 2'(3 - i), 2'(i));
            tick();
        end
        nvec++;
        if (count_o !== 3'd3) begin
            nfail++;
            $display("FAIL flush_pre got=%0d exp=3", count_o);
        end
        flush_i = 1'b1; op_ready_i = 1'b1;
        tick();
        flush_i = 1'b0; op_ready_i = 1'b0;
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        nvec++;
        if (count_o !== 3'd0 || op_valid_o !== 1'b0) begin
            nfail++;
            $display("FAIL flush_clear got=%0d/%b exp=0/0", count_o, op_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'(i), 2'(i), 2'(i));
            tick();
        end
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        nvec++;
        if (count_o !== 3'd0 || op_valid_o !== 1'b0 || in_ready_o !== 1'b1 || {a_o, b_o, sel_o} !== 6'd0) begin
            nfail++;
            $display("FAIL async_reset got=%0d/%b/%b exp=0/0/1", count_o, op_valid_o, in_ready_o);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

`ifdef ALU_OP_QUEUE_STATS_EN
    task automatic test_stats();
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        op_ready_i = 1'b0;
        drive(1'b1, 2'd1, 2'd1, 2'd1);
        repeat (4 + 300) tick();
        nvec++;
        if (stall_cnt_o !== 8'd255) begin
            nfail++;
            $display("FAIL stats_stall got=%0d exp=255", stall_cnt_o);
        end
        drive(1'b0, 2'd0, 2'd0, 2'd0);
        op_ready_i = 1'b1;
        repeat (4) tick();
        op_ready_i = 1'b0;
        nvec++;
        if (issued_cnt_o !== 8'd4) begin
            nfail++;
            $display("FAIL stats_issued got=%0d exp=4", issued_cnt_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_order();
        test_full_pop();
        test_wrap();
        test_flush_reset();
`ifdef ALU_OP_QUEUE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
